// File: rtl/brg_pkg.sv
// Shared constants for the fractional baud-rate generator: 125 MHz divisor
// presets (16x oversampling), oversample default, divisor clamp and update FSM states.
package brg_pkg;

    localparam int unsigned OSR_DEF         = 16;
    localparam int unsigned MIN_DIV         = 2;

    // 125e6 / (16 * baud), split into integer and 1/16ths
    localparam int unsigned DIV_9600_INT    = 813;
    localparam int unsigned DIV_9600_FRAC   = 13;
    localparam int unsigned DIV_19200_INT   = 406;
    localparam int unsigned DIV_19200_FRAC  = 14;
    localparam int unsigned DIV_38400_INT   = 203;
    localparam int unsigned DIV_38400_FRAC  = 7;
    localparam int unsigned DIV_115200_INT  = 67;
    localparam int unsigned DIV_115200_FRAC = 13;

    typedef enum logic {
        UPD_IDLE = 1'b0,
        UPD_PEND = 1'b1
    } upd_state_e;

endpackage

// File: rtl/brg_frac_tick.sv
// Oversample divider: os_cnt plus fractional accumulator, emits a registered os_tick.
// The accumulator is only built when BRG_FRAC_EN is defined; otherwise the period is div_int_i.
module brg_frac_tick #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic [INT_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              wrap_o,
    output logic              os_tick_o
);

    logic [INT_W:0] os_cnt_q;
    logic [INT_W:0] period;
    logic           os_tick_q;

`ifdef BRG_FRAC_EN
    logic [FRAC_W-1:0] frac_acc_q;
    logic              carry_q;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, div_frac_i};
    // Overflow of the previous add stretches the current period by one cycle
    assign period   = {1'b0, div_int_i} + (INT_W + 1)'(carry_q);
`else
    logic unused_frac;

    assign unused_frac = ^div_frac_i;
    assign period      = {1'b0, div_int_i};
`endif

    assign wrap_o    = en_i && (os_cnt_q == period - (INT_W + 1)'(1));
    assign os_tick_o = os_tick_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
`ifdef BRG_FRAC_EN
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
`endif
        end else begin
            os_tick_q <= wrap_o;
            if (en_i) begin
                if (wrap_o) begin
                    os_cnt_q   <= '0;
`ifdef BRG_FRAC_EN
                    frac_acc_q <= frac_sum[FRAC_W-1:0];
                    carry_q    <= frac_sum[FRAC_W];
`endif
                end else begin
                    os_cnt_q <= os_cnt_q + (INT_W + 1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/brg_frac.sv
// Fractional baud-rate generator top: phase counter, baud tick/clock and divisor update handshake.
// Fractional division is enabled by defining BRG_FRAC_EN.
module brg_frac
    import brg_pkg::*;
#(
    parameter int unsigned INT_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OSR          = OSR_DEF,
    parameter int unsigned RST_DIV_INT  = DIV_115200_INT,
    parameter int unsigned RST_DIV_FRAC = DIV_115200_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_valid,
    output logic              div_ready,
    output logic              os_tick,
    output logic              baud_tick,
    output logic              baud_clk,
    output logic              upd_pend
);

    localparam int unsigned     PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(OSR / 2 - 1);

    upd_state_e        state_q;
    logic [INT_W-1:0]  act_int_q;
    logic [FRAC_W-1:0] act_frac_q;
    logic [INT_W-1:0]  shd_int_q;
    logic [INT_W-1:0]  shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q;
    logic [PH_W-1:0]   ph_q;
    logic              baud_tick_q;
    logic              baud_clk_q;
    logic              os_wrap;
    logic              xfer;
    logic              apply;

    assign div_ready = (state_q == UPD_IDLE);
    assign upd_pend  = (state_q == UPD_PEND);
    assign baud_tick = baud_tick_q;
    assign baud_clk  = baud_clk_q;

    assign xfer      = div_valid && div_ready;
    // Applied in the cycle after the boundary tick, so a transfer made during
    // that tick cycle is still pending and waits for the following boundary.
    assign apply     = upd_pend && (baud_tick_q || !en);
    assign shd_int_d = (div_int < INT_W'(MIN_DIV)) ? INT_W'(MIN_DIV) : div_int;

    brg_frac_tick #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .clear_i    (apply),
        .div_int_i  (act_int_q),
        .div_frac_i (act_frac_q),
        .wrap_o     (os_wrap),
        .os_tick_o  (os_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UPD_IDLE;
            act_int_q   <= INT_W'(RST_DIV_INT);
            act_frac_q  <= FRAC_W'(RST_DIV_FRAC);
            shd_int_q   <= '0;
            shd_frac_q  <= '0;
            ph_q        <= '0;
            baud_tick_q <= 1'b0;
            baud_clk_q  <= 1'b0;
        end else begin
            baud_tick_q <= 1'b0;
            if (apply) begin
                state_q    <= UPD_IDLE;
                act_int_q  <= shd_int_q;
                act_frac_q <= shd_frac_q;
                ph_q       <= '0;
            end else if (os_wrap) begin
                ph_q        <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
                baud_tick_q <= (ph_q == PH_LAST);
                if (ph_q == PH_HALF) begin
                    baud_clk_q <= 1'b1;
                end else if (ph_q == PH_LAST) begin
                    baud_clk_q <= 1'b0;
                end
            end
            if (xfer) begin
                state_q    <= UPD_PEND;
                shd_int_q  <= shd_int_d;
                shd_frac_q <= div_frac;
            end
        end
    end

endmodule

// File: tb/tb_brg_frac.sv
// Self-checking bench for brg_frac: per-cycle comparison against a period-level
// reference model plus directed rate measurements. Honours BRG_FRAC_EN.
`timescale 1ns/1ps
module tb_brg_frac;

    localparam int unsigned INT_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OSR    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_valid;
    logic              div_ready;
    logic              os_tick;
    logic              baud_tick;
    logic              baud_clk;
    logic              upd_pend;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brg_frac #(
        .INT_W        (INT_W),
        .FRAC_W       (FRAC_W),
        .OSR          (OSR),
        .RST_DIV_INT  (67),
        .RST_DIV_FRAC (13)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .os_tick   (os_tick),
        .baud_tick (baud_tick),
        .baud_clk  (baud_clk),
        .upd_pend  (upd_pend)
    );

    // Reference model: period k after the last restart lasts A_int cycles plus
    // the carry that the running sum k*A_frac produced crossing a 2^FRAC_W step.
    longint      m_int, m_frac, s_int, s_frac, m_k, m_el, m_ph;
    bit          m_pend, m_os, m_bt, m_bclk;

    function automatic longint extra_of(input longint k, input longint f);
        if (k == 0) return 0;
        return (k * f) / (64'd1 << FRAC_W) - ((k - 1) * f) / (64'd1 << FRAC_W);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit     ready;
        bit     applied;
        longint len;
        longint f;
        ready = !m_pend;
        if (reset) begin
            m_int = 67; m_frac = 13; m_k = 0; m_el = 0; m_ph = 0;
            m_pend = 0; m_os = 0; m_bt = 0; m_bclk = 0;
            return;
        end
        applied = m_pend && (m_bt || !en);
        m_os = 0;
        m_bt = 0;
`ifdef BRG_FRAC_EN
        f = m_frac;
`else
        f = 0;
`endif
        if (applied) begin
            m_int = s_int; m_frac = s_frac; m_k = 0; m_el = 0; m_ph = 0; m_pend = 0;
        end else if (en) begin
            len = m_int + extra_of(m_k, f);
            m_el++;
            if (m_el == len) begin
                m_el = 0;
                m_k++;
                m_os = 1;
                if (m_ph == OSR - 1) begin
                    m_bt = 1; m_bclk = 0; m_ph = 0;
                end else begin
                    if (m_ph == OSR / 2 - 1) m_bclk = 1;
                    m_ph++;
                end
            end
        end
        if (ready && div_valid) begin
            s_int  = (div_int < 2) ? 2 : longint'(div_int);
            s_frac = longint'(div_frac);
            m_pend = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("os_tick",   64'(os_tick),   64'(m_os));
        chk("baud_tick", 64'(baud_tick), 64'(m_bt));
        chk("baud_clk",  64'(baud_clk),  64'(m_bclk));
        chk("upd_pend",  64'(upd_pend),  64'(m_pend));
        chk("div_ready", 64'(div_ready), 64'(!m_pend));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (upd_pend && n < 4000) begin cyc(); n++; end
        chk("idle_reached", 64'(upd_pend), 64'd0);
    endtask

    task automatic load(input int unsigned di, input int unsigned df);
        wait_idle();
        div_int   = INT_W'(di);
        div_frac  = FRAC_W'(df);
        div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        chk("load_pend", 64'(upd_pend), 64'd1);
    endtask

    task automatic wait_bt(input int lim, output int n, output int hi);
        n  = 0;
        hi = 0;
        do begin
            cyc();
            n++;
            if (baud_clk) hi++;
        end while (!baud_tick && n < lim);
        chk("bt_seen", 64'(baud_tick), 64'd1);
    endtask

    // Load a divisor, let it apply, skip the first (restart) baud period and measure the next
    task automatic rate(input string tag, input int unsigned di, input int unsigned df,
                        input int exp_n, input int exp_hi);
        int n, hi;
        load(di, df);
        div_int   = INT_W'(9);
        div_valid = 1'b1;
        chk({tag, "_blocked"}, 64'(div_ready), 64'd0);
        cyc();
        div_valid = 1'b0;
        wait_idle();
        wait_bt(3000, n, hi);
        wait_bt(3000, n, hi);
        chk({tag, "_baud_cycles"}, 64'(n), 64'(exp_n));
        chk({tag, "_bclk_high"}, 64'(hi), 64'(exp_hi));
    endtask

    initial begin
        int  n, t, exp_total;
        logic held;
        reset = 1'b1; en = 1'b0; div_valid = 1'b0; div_int = '0; div_frac = '0;
        m_pend = 0; m_bt = 0;
        repeat (3) cyc();
        chk("rst_os_tick", 64'(os_tick), 64'd0);
        chk("rst_baud_clk", 64'(baud_clk), 64'd0);
        chk("rst_div_ready", 64'(div_ready), 64'd1);

        // Default divisor 67 + 13/16 over 512 oversample periods
        reset = 1'b0;
        en    = 1'b1;
        n = 0; t = 0;
        while (t < 512 && n < 40000) begin
            cyc();
            n++;
            if (os_tick) t++;
        end
        chk("mean_ticks", 64'(t), 64'd512);
`ifdef BRG_FRAC_EN
        exp_total = 34720;
`else
        exp_total = 34304;
`endif
        chk("mean_drift", 64'((n >= exp_total - 1) && (n <= exp_total + 1)), 64'd1);

        rate("div4_0", 4, 0, 64, 32);
`ifdef BRG_FRAC_EN
        rate("div4_8", 4, 8, 72, 36);
`else
        rate("div4_8", 4, 8, 64, 32);
`endif
        rate("div1", 1, 0, 32, 16);
        rate("div0", 0, 0, 32, 16);

        // en low mid-period freezes everything
        load(4, 0);
        wait_idle();
        repeat (6) cyc();
        held = baud_clk;
        en   = 1'b0;
        repeat (10) cyc();
        chk("en_hold_bclk", 64'(baud_clk), 64'(held));
        en = 1'b1;
        repeat (40) cyc();

        // Reset during a pending update
        load(5, 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstpend_upd_pend", 64'(upd_pend), 64'd0);
        chk("rstpend_baud_clk", 64'(baud_clk), 64'd0);
        chk("rstpend_os_tick", 64'(os_tick), 64'd0);
        repeat (200) cyc();

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            div_valid = ($urandom_range(0, 19) == 0);
            div_int   = INT_W'($urandom_range(0, 6));
            div_frac  = FRAC_W'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 999) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brg_frac.md
Name: brg_frac

Overview:
Programmable fractional baud-rate generator for the UART path. It replaces fixed per-rate divider chains with one runtime-loadable divisor. The divisor is integer plus fractional, so 125 MHz can hit standard baud rates with under 0.1% average error. Outputs an oversample tick (for the RX sampler), a 1x baud tick (for TX shift) and a 50%-duty baud clock.

Parameters:
INT_W, 16, width of integer divisor part
FRAC_W, 4, width of fractional divisor part (units of 1/2^FRAC_W cycle)
OSR, 16, oversample ticks per baud period; even, >=4
RST_DIV_INT, 67, integer divisor loaded at reset (125 MHz / (115200*16) = 67.82)
RST_DIV_FRAC, 13, fractional divisor loaded at reset (0.82*16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  count enable; low freezes all counters
div_int  in  INT_W  requested integer divisor
div_frac  in  FRAC_W  requested fractional divisor
div_valid  in  1  divisor update request
div_ready  out  1  block can accept a divisor update
os_tick  out  1  one-cycle pulse per oversample period
baud_tick  out  1  one-cycle pulse per baud period, coincident with the OSR-th os_tick
baud_clk  out  1  square wave at baud rate
upd_pend  out  1  accepted divisor not yet applied

Behaviour:
- Reset (clk edge with reset=1):
  - os_cnt=0, frac_acc=0, ph_cnt=0.
  - Active divisor = RST_DIV_INT/RST_DIV_FRAC.
  - os_tick=0, baud_tick=0, baud_clk=0, upd_pend=0, div_ready=1.
  - Reset mid-operation discards any pending update.
- Oversample divider (en=1):
  - os_cnt counts 0..P-1, where P = A_int + carry and carry is the latched overflow from the previous frac_acc add.
  - os_tick is registered and asserts for one cycle, one cycle after os_cnt==P-1.
  - On the period end: os_cnt<=0 and frac_acc<=(frac_acc+A_frac) mod 2^FRAC_W. Any overflow extends the next period by one cycle.
  - Average period is A_int + A_frac/2^FRAC_W cycles.
- Phase counter:
  - ph_cnt counts os periods 0..OSR-1 and wraps.
  - baud_tick pulses with the os_tick that ends period OSR-1.
  - baud_clk goes high with the os_tick ending period OSR/2-1 and low with the os_tick ending period OSR-1.
- Divisor handshake:
  - Transfer occurs when div_valid && div_ready.
  - On transfer, the value is captured into a shadow register; upd_pend=1 and div_ready=0.
  - Captured div_int < 2 is clamped to 2.
  - The shadow becomes active at the next baud period boundary (the cycle baud_tick asserts), or on the next cycle if en=0.
  - On apply: frac_acc=0, os_cnt=0, ph_cnt=0, upd_pend=0, div_ready=1.
  - A transfer in the same cycle as baud_tick is applied at the following boundary, not the current one.
- en=0:
  - All counters and baud_clk hold.
  - os_tick and baud_tick are 0.
  - The handshake remains operational.
- Width rules:
  - os_cnt is INT_W+1 bits.
  - ph_cnt is clog2(OSR) bits.
  - No counter can overflow for legal divisors.

Optional Feature:
BRG_FRAC_EN
- Defined: fractional accumulator present as specified above.
- Undefined: div_frac and RST_DIV_FRAC are ignored, frac_acc is not built, and P = A_int always. The port list is unchanged.

Decomposition:
- Package brg_pkg holds:
  - default divisor constants for 9600/19200/38400/115200 at 125 MHz (int and frac pairs);
  - an OSR default;
  - the MIN_DIV=2 clamp constant.
- Sub-module brg_frac_tick contains os_cnt plus frac_acc and emits os_tick. The top module holds the phase counter, baud outputs and update handshake.

Test Plan:
- Reset then en=1 with defaults (67/13, FRAC_W=4): over 16000 os_ticks, mean period is 67.8125 cycles ±1 cycle total drift. Every individual period is 67 or 68.
- Load div_int=4, div_frac=0: os_tick every 4 cycles, baud_tick every 64 cycles, baud_clk high 32 / low 32.
- Load div_int=4, div_frac=8: periods alternate 4,5,4,5, so 16 os_ticks take 72 cycles. With BRG_FRAC_EN undefined, periods are all 4.
- Update mid-baud-period: div_ready drops and upd_pend=1, the old rate continues until baud_tick, then the new rate starts from os_cnt=0. A second div_valid during pend is not accepted.
- Load div_int=1: behaves as 2, so os_tick every 2 cycles. Load div_int=0: same.
- en toggled low for 10 cycles mid-period: no ticks, baud_clk frozen, and the period resumes with the remaining count. Reset asserted mid-pend: upd_pend=0, defaults restored, all outputs 0 the next cycle.
